// File: rtl/pi_series_sequencer.sv
// rtl/pi_series_sequencer.sv - Leibniz-series pi sequencer driving a shared external divider
//
// Computes pi ~= sum_k (-1)^k * M/(2k+1) with M = 4*2^(4*Q), one divider
// request per term, accumulating signed quotients modulo 2^NBITS.
//
// Optional feature macro: PI_SEQ_EARLY_STOP_EN
//   defined     - a zero quotient in WAIT finishes the run after accumulating it
//   not defined - every run evaluates exactly n_terms terms
//
// Ports:
//   clk_2      in   clock, all state changes on rising edge
//   reset      in   synchronous active-high reset
//   start      in   start request, honoured in IDLE or DONE
//   n_terms    in   number of terms, captured on an accepted start
//   busy       out  high in ISSUE and WAIT
//   done       out  high in DONE
//   pi         out  accumulator, value x 2^-(4*Q)
//   terms_done out  terms accumulated so far
//   div_start  out  one-cycle divider request
//   div_num    out  dividend, constant M
//   div_den    out  divisor 2k+1
//   div_done   in   divider completion pulse
//   div_quot   in   unsigned quotient, valid with div_done

module pi_series_sequencer #(
    parameter int NBITS   = 64,
    parameter int Q       = 15,
    parameter int NTERM_W = 16
) (
    input  logic               clk_2,
    input  logic               reset,
    input  logic               start,
    input  logic [NTERM_W-1:0] n_terms,
    output logic               busy,
    output logic               done,
    output logic [NBITS-1:0]   pi,
    output logic [NTERM_W-1:0] terms_done,
    output logic               div_start,
    output logic [NBITS-1:0]   div_num,
    output logic [NBITS-1:0]   div_den,
    input  logic               div_done,
    input  logic [NBITS-1:0]   div_quot
);

    localparam logic [NBITS-1:0] M_CONST = NBITS'(1) << (4 * Q + 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [NTERM_W-1:0] n_lat;
    logic               accept;
    logic               term_fin;
    logic               last_term;
    logic               early_stop;

    // The term index k always equals the number of terms accumulated, so
    // terms_done doubles as k rather than keeping a second copy.
    assign accept    = ((state == IDLE) || (state == DONE)) && start;
    assign term_fin  = (state == WAIT) && div_done;
    assign last_term = ((terms_done + NTERM_W'(1)) == n_lat);

`ifdef PI_SEQ_EARLY_STOP_EN
    assign early_stop = (div_quot == '0);
`else
    assign early_stop = 1'b0;
`endif

    always_ff @(posedge clk_2) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = (n_terms == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (div_done) begin
                    state_nxt = (last_term || early_stop) ? DONE : ISSUE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_2) begin
        if (reset) begin
            pi         <= '0;
            terms_done <= '0;
            n_lat      <= '0;
        end else if (accept) begin
            pi         <= '0;
            terms_done <= '0;
            n_lat      <= n_terms;
        end else if (term_fin) begin
            // Odd terms of the series are subtracted.
            pi         <= terms_done[0] ? (pi - div_quot) : (pi + div_quot);
            terms_done <= terms_done + NTERM_W'(1);
        end
    end

    assign busy      = (state == ISSUE) || (state == WAIT);
    assign done      = (state == DONE);
    assign div_start = (state == ISSUE);
    assign div_num   = M_CONST;
    assign div_den   = {{(NBITS - NTERM_W - 1){1'b0}}, terms_done, 1'b1};

endmodule
